// File: rtl/bsg_pkg.sv
// Shared definitions for the bsg register interface:
// transmit FSM states, CTRL bit positions and default sizing.
package bsg_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_BUSY  = 2'd2
    } tx_state_e;

    localparam int CTRL_TXEN    = 0;
    localparam int CTRL_INTMSK  = 1;
    localparam int CTRL_INTFLAG = 2;
    localparam int CTRL_STATUS  = 3;
    localparam int CTRL_ERR     = 4;
    localparam int CTRL_GO      = 5;

    localparam int         DEF_DW   = 8;
    localparam int         DEF_AW   = 8;
    localparam int         DEF_NCH  = 4;
    localparam logic [7:0] DEF_BASE = 8'h10;

endpackage

// File: rtl/bsg_reg_if_if.sv
// Simple valid/ready register bus: one request per
// accepted cycle, read data returned one edge later.
interface bsg_reg_if_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wr;
    logic          valid;
    logic          ready;
    logic [DW-1:0] rdata;

    modport master (
        output addr, wdata, wr, valid,
        input  ready, rdata
    );

    modport slave (
        input  addr, wdata, wr, valid,
        output ready, rdata
    );
endinterface

// File: rtl/bsg_tx_seq.sv
// Transmit sequencer: IDLE -> START (one-cycle start
// pulse) -> BUSY until the transmitter reports done.
module bsg_tx_seq
    import bsg_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    input  logic abort,
    input  logic tx_done,
    output logic tx_start,
    output logic busy,
    output logic done_evt
);

    tx_state_e state_q, state_d;

    // State register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= TX_IDLE;
        else        state_q <= state_d;
    end

    // Next state; abort wins over a coincident tx_done.
    always_comb begin
        state_d  = state_q;
        tx_start = 1'b0;
        done_evt = 1'b0;
        busy     = (state_q != TX_IDLE);
        unique case (state_q)
            TX_IDLE: begin
                if (go) state_d = TX_START;
            end
            TX_START: begin
                tx_start = 1'b1;
                state_d  = abort ? TX_IDLE : TX_BUSY;
            end
            TX_BUSY: begin
                if (abort) begin
                    state_d = TX_IDLE;
                end else if (tx_done) begin
                    state_d  = TX_IDLE;
                    done_evt = 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/bsg_reg_if.sv
// Register block: CTRL plus NCH channel data registers,
// driving a transmit sequencer and a masked interrupt.
module bsg_reg_if
    import bsg_pkg::*;
#(
    parameter int            DW   = DEF_DW,
    parameter int            AW   = DEF_AW,
    parameter int            NCH  = DEF_NCH,
    parameter logic [AW-1:0] BASE = AW'(DEF_BASE)
) (
    input  logic              clk,
    input  logic              rst_n,
    bsg_reg_if_if.slave       bus,
    output logic [NCH*DW-1:0] ch_data,
    output logic              tx_en,
    output logic              tx_start,
    input  logic              tx_done,
    output logic              irq
);

    logic [AW-1:0]     off;
    logic [AW-1:0]     ch_idx;
    logic              is_ctrl, is_ch, unmapped;
    logic              xfer, ctrl_wr, ch_wr;
    logic              status, done_evt;
    logic              go_req, go_ok, go_err;
    logic              abort, err_set;

    logic              txen_q, txen_d;
    logic              intmsk_q, intmsk_d;
    logic              intflag_q, intflag_d;
    logic              err_q, err_d;
    logic              irq_q, irq_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [NCH*DW-1:0] ch_q, ch_d;
    logic [DW-1:0]     ctrl_rd, rd_mux;

    // Address decode relative to CTRL.
    assign off      = bus.addr - BASE;
    assign ch_idx   = off - AW'(1);
    assign is_ctrl  = (bus.addr == BASE);
    assign is_ch    = (off >= AW'(1)) && (off <= AW'(NCH));
    assign unmapped = ~is_ctrl & ~is_ch;

    // Channel writes stall while a transmission is live.
    assign bus.ready = ~(bus.wr & is_ch & status);
    assign xfer      = bus.valid & bus.ready;
    assign ctrl_wr   = xfer & bus.wr & is_ctrl;
    assign ch_wr     = xfer & bus.wr & is_ch;

    assign go_req  = ctrl_wr & bus.wdata[CTRL_GO];
    assign go_ok   = go_req & bus.wdata[CTRL_TXEN] & ~status;
    assign go_err  = go_req & ~go_ok;
    assign abort   = ctrl_wr & ~bus.wdata[CTRL_TXEN] & status;
    assign err_set = (xfer & unmapped) | go_err;

    bsg_tx_seq u_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go_ok),
        .abort    (abort),
        .tx_done  (tx_done),
        .tx_start (tx_start),
        .busy     (status),
        .done_evt (done_evt)
    );

    // CTRL readback image; GO and upper bits read as zero.
    always_comb begin
        ctrl_rd               = '0;
        ctrl_rd[CTRL_TXEN]    = txen_q;
        ctrl_rd[CTRL_INTMSK]  = intmsk_q;
        ctrl_rd[CTRL_INTFLAG] = intflag_q;
        ctrl_rd[CTRL_STATUS]  = status;
        ctrl_rd[CTRL_ERR]     = err_q;
    end

    // Read mux; unmapped addresses return zero.
    always_comb begin
        rd_mux = '0;
        if (is_ctrl)    rd_mux = ctrl_rd;
        else if (is_ch) rd_mux = ch_q[int'(ch_idx)*DW +: DW];
    end

    // Next-state for all bus-visible registers.
    // Hardware set of INTFLAG/ERR dominates a W1C.
    always_comb begin
        txen_d   = txen_q;
        intmsk_d = intmsk_q;
        if (ctrl_wr) begin
            txen_d   = bus.wdata[CTRL_TXEN];
            intmsk_d = bus.wdata[CTRL_INTMSK];
        end
        intflag_d = (intflag_q
                  & ~(ctrl_wr & bus.wdata[CTRL_INTFLAG]))
                  | done_evt;
        err_d     = (err_q
                  & ~(ctrl_wr & bus.wdata[CTRL_ERR]))
                  | err_set;
        ch_d = ch_q;
        if (ch_wr) ch_d[int'(ch_idx)*DW +: DW] = bus.wdata;
        rdata_d = (xfer & ~bus.wr) ? rd_mux : rdata_q;
        irq_d   = intflag_q & intmsk_q;
    end

    // Register update with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txen_q    <= 1'b0;
            intmsk_q  <= 1'b0;
            intflag_q <= 1'b0;
            err_q     <= 1'b0;
            irq_q     <= 1'b0;
            rdata_q   <= '0;
            ch_q      <= '0;
        end else begin
            txen_q    <= txen_d;
            intmsk_q  <= intmsk_d;
            intflag_q <= intflag_d;
            err_q     <= err_d;
            irq_q     <= irq_d;
            rdata_q   <= rdata_d;
            ch_q      <= ch_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign ch_data   = ch_q;
    assign tx_en     = txen_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_bsg_reg_if.sv
// Directed self-checking bench for bsg_reg_if.
// Expected values are hand-computed constants.
module tb_bsg_reg_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_done;
    logic [31:0] ch_data;
    logic        tx_en;
    logic        tx_start;
    logic        irq;

    int n_run  = 0;
    int n_fail = 0;

    bsg_reg_if_if #(.DW(8), .AW(8)) bus ();

    bsg_reg_if dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ch_data  (ch_data),
        .tx_en    (tx_en),
        .tx_start (tx_start),
        .tx_done  (tx_done),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // One bus cycle; optional tx_done pulse on the same edge.
    task automatic xfer(input logic w, input logic [7:0] a,
                        input logic [7:0] d, input logic td);
        @(negedge clk);
        bus.valid = 1'b1;
        bus.wr    = w;
        bus.addr  = a;
        bus.wdata = d;
        tx_done   = td;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        bus.wr    = 1'b0;
        tx_done   = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        tx_done = 1'b1;
        @(posedge clk);
        #1;
        tx_done = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        tx_done   = 1'b0;
        bus.valid = 1'b0;
        bus.wr    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.ready), 1);
        check("rst_irq", 32'(irq), 0);
        check("rst_txstart", 32'(tx_start), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset-state readback
        xfer(0, 8'h10, 8'h00, 0);
        check("rd_ctrl_rst", 32'(bus.rdata), 'h00);
        check("irq_idle", 32'(irq), 0);
        check("ready_idle", 32'(bus.ready), 1);

        // Channel 1 write / read
        xfer(1, 8'h12, 8'hA5, 0);
        xfer(0, 8'h12, 8'h00, 0);
        check("rd_ch1", 32'(bus.rdata), 'hA5);
        check("ch1_out", 32'(ch_data[15:8]), 'hA5);
        check("ch0_out", 32'(ch_data[7:0]), 'h00);

        // Start, done, interrupt, W1C
        xfer(1, 8'h10, 8'h23, 0);
        check("txstart_hi", 32'(tx_start), 1);
        check("txen_hi", 32'(tx_en), 1);
        @(posedge clk);
        #1;
        check("txstart_lo", 32'(tx_start), 0);
        xfer(0, 8'h10, 8'h00, 0);
        check("ctrl_busy", 32'(bus.rdata), 'h0B);
        repeat (2) @(posedge clk);
        pulse_done();
        check("irq_lag", 32'(irq), 0);
        @(posedge clk);
        #1;
        check("irq_set", 32'(irq), 1);
        xfer(0, 8'h10, 8'h00, 0);
        check("ctrl_done", 32'(bus.rdata), 'h07);
        xfer(1, 8'h10, 8'h07, 0);
        check("irq_hold", 32'(irq), 1);
        @(posedge clk);
        #1;
        check("irq_clr", 32'(irq), 0);
        xfer(0, 8'h10, 8'h00, 0);
        check("ctrl_w1c", 32'(bus.rdata), 'h03);

        // Channel write stalled while busy
        xfer(1, 8'h10, 8'h23, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.valid = 1'b1;
        bus.wr    = 1'b1;
        bus.addr  = 8'h11;
        bus.wdata = 8'h5A;
        #1;
        check("busy_ready", 32'(bus.ready), 0);
        @(posedge clk);
        #1;
        check("ch_hold", 32'(ch_data[7:0]), 'h00);
        @(negedge clk);
        tx_done = 1'b1;
        #1;
        check("busy_ready2", 32'(bus.ready), 0);
        @(posedge clk);
        #1;
        tx_done = 1'b0;
        check("ready_after", 32'(bus.ready), 1);
        check("ch_hold2", 32'(ch_data[7:0]), 'h00);
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        bus.wr    = 1'b0;
        check("ch_done", 32'(ch_data[7:0]), 'h5A);
        xfer(1, 8'h10, 8'h07, 0);
        xfer(0, 8'h10, 8'h00, 0);
        check("ctrl_clr2", 32'(bus.rdata), 'h03);

        // tx_done and W1C of INTFLAG on the same edge
        xfer(1, 8'h10, 8'h23, 0);
        @(posedge clk);
        #1;
        xfer(1, 8'h10, 8'h07, 1);
        xfer(0, 8'h10, 8'h00, 0);
        check("set_wins", 32'(bus.rdata), 'h07);
        xfer(1, 8'h10, 8'h07, 0);

        // GO while busy, then abort
        xfer(1, 8'h10, 8'h23, 0);
        @(posedge clk);
        #1;
        xfer(1, 8'h10, 8'h23, 0);
        xfer(0, 8'h10, 8'h00, 0);
        check("go_busy_err", 32'(bus.rdata), 'h1B);
        xfer(1, 8'h10, 8'h00, 0);
        check("abort_txen", 32'(tx_en), 0);
        xfer(0, 8'h10, 8'h00, 0);
        check("abort_ctrl", 32'(bus.rdata), 'h10);
        pulse_done();
        xfer(0, 8'h10, 8'h00, 0);
        check("done_idle", 32'(bus.rdata), 'h10);
        check("irq_idle2", 32'(irq), 0);
        xfer(1, 8'h10, 8'h10, 0);
        xfer(0, 8'h10, 8'h00, 0);
        check("err_w1c", 32'(bus.rdata), 'h00);

        // GO with TXENABLE=0
        xfer(1, 8'h10, 8'h20, 0);
        xfer(0, 8'h10, 8'h00, 0);
        check("go_noen", 32'(bus.rdata), 'h10);
        xfer(1, 8'h10, 8'h10, 0);

        // Unmapped accesses
        xfer(0, 8'h12, 8'h00, 0);
        xfer(0, 8'h15, 8'h00, 0);
        check("unmap_rd", 32'(bus.rdata), 'h00);
        xfer(0, 8'h10, 8'h00, 0);
        check("unmap_err", 32'(bus.rdata), 'h10);
        xfer(1, 8'h0F, 8'hFF, 0);
        check("unmap_wr", ch_data, 32'h0000A55A);
        xfer(1, 8'h10, 8'h10, 0);

        // Asynchronous reset in BUSY
        xfer(1, 8'h14, 8'h3C, 0);
        xfer(0, 8'h14, 8'h00, 0);
        check("rd_ch3", 32'(bus.rdata), 'h3C);
        xfer(1, 8'h10, 8'h23, 0);
        @(posedge clk);
        #1;
        check("busy_txen", 32'(tx_en), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ch", ch_data, 0);
        check("arst_txen", 32'(tx_en), 0);
        check("arst_txs", 32'(tx_start), 0);
        check("arst_irq", 32'(irq), 0);
        check("arst_rdata", 32'(bus.rdata), 0);
        check("arst_ready", 32'(bus.ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_done();
        @(posedge clk);
        #1;
        check("post_irq", 32'(irq), 0);
        xfer(0, 8'h10, 8'h00, 0);
        check("post_ctrl", 32'(bus.rdata), 'h00);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/bsg_reg_if.md
BSG_REG_IF -- requirements
Module: bsg_reg_if

Interface
REQ-001 Parameter DW, default 8, data/register width (>=6).
REQ-002 Parameter AW, default 8, address width.
REQ-003 Parameter NCH, default 4, number of channel data registers (1..15).
REQ-004 Parameter BASE, default 8'h10, address of CTRL; channel k (0..NCH-1) at BASE+1+k.
REQ-005 The block SHALL have exactly one clock, clk, and one reset, rst_n, which is asynchronous and active-low.
REQ-006 clk  in  1  clock, all state on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 addr  in  AW  bus address.
REQ-009 wdata  in  DW  bus write data.
REQ-010 wr  in  1  1 = write, 0 = read.
REQ-011 valid  in  1  bus request present.
REQ-012 ready  out  1  slave accepts request this cycle.
REQ-013 rdata  out  DW  read data, registered.
REQ-014 ch_data  out  NCH*DW  channel registers, channel k at bits [k*DW +: DW].
REQ-015 tx_en  out  1  CTRL.TXENABLE.
REQ-016 tx_start  out  1  one-cycle transmission start pulse.
REQ-017 tx_done  in  1  one-cycle pulse from transmitter core.
REQ-018 irq  out  1  registered INTFLAG & INTMSK.

Function
REQ-019 Transfer SHALL occur when valid & ready at a rising clk edge; no other condition changes register state via the bus.
REQ-020 CTRL bits SHALL be: 0 TXENABLE rw, 1 INTMSK rw, 2 INTFLAG W1C, 3 STATUS ro (1 when FSM not IDLE), 4 ERR W1C, 5 GO write-only (reads 0); bits DW-1..6 read 0.
REQ-021 ready SHALL be 0 only for a write to a channel address while STATUS=1; otherwise 1.
REQ-022 A read transfer SHALL load rdata with the addressed register on the same edge (1-cycle latency); rdata holds until the next read transfer.
REQ-023 A read or write to an unmapped address SHALL return rdata=0, modify no register, and set ERR.
REQ-024 FSM states IDLE, START, BUSY: IDLE->START on CTRL write with GO=1 while resulting TXENABLE=1; START->BUSY unconditionally (tx_start=1 only in START); BUSY->IDLE on tx_done.
REQ-025 BUSY->IDLE on tx_done SHALL set INTFLAG.
REQ-026 A CTRL write clearing TXENABLE in START or BUSY SHALL abort to IDLE on that edge without setting INTFLAG.
REQ-027 GO=1 written while not IDLE, or with resulting TXENABLE=0, SHALL be ignored and set ERR.
REQ-028 CTRL writes SHALL update TXENABLE/INTMSK in any state.
REQ-029 Simultaneous INTFLAG set (tx_done) and W1C of INTFLAG SHALL leave INTFLAG=1; same rule for ERR set vs. clear.
REQ-030 tx_done while IDLE or START SHALL be ignored.
REQ-031 irq SHALL update one cycle after INTFLAG or INTMSK changes.

Reset
REQ-032 On rst_n=0 all of CTRL, ch_data, rdata, irq, tx_start SHALL go to 0 and FSM to IDLE immediately, regardless of clk.
REQ-033 Reset during BUSY SHALL discard the transmission; no INTFLAG after release.
REQ-034 ready SHALL be 1 while in reset (STATUS=0).

Structure
REQ-035 Shared package bsg_pkg SHALL hold the FSM enum, CTRL bit-index constants, and default DW/AW/NCH/BASE.
REQ-036 The FSM SHALL be a sub-module bsg_tx_seq (inputs go, abort, tx_done; outputs tx_start, busy, done_evt).

Verification
REQ-037 Reset then read BASE -> rdata=8'h00, irq=0, ready=1.
REQ-038 Write BASE+2=8'hA5, read BASE+2 -> rdata=8'hA5, ch_data[15:8]=8'hA5.
REQ-039 Write CTRL=8'h23, pulse tx_done 5 cycles later -> tx_start high 1 cycle, STATUS=1 until tx_done, then INTFLAG=1, irq=1 next cycle; write CTRL=8'h07 -> INTFLAG=0, irq=0.
REQ-040 During BUSY, write BASE+1 with valid held -> ready=0, ch_data unchanged until tx_done, then write completes.
REQ-041 During BUSY write CTRL=8'h00 -> FSM IDLE, INTFLAG=0; GO during BUSY -> ERR=1.
REQ-042 Read address BASE+NCH+1 -> rdata=0, ERR=1; assert rst_n=0 mid-BUSY -> all outputs 0 asynchronously.
